dmem_responder: RTL and testbench

- Responder-side data memory for the pipelined CPU's load/store port. The CPU is the initiator.
- Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns read data or a write completion as a single-cycle response pulse.
- Also drives a stall indication back to the pipeline.
- Used as the data-memory model in CPU-level benches and as the synthesizable scratchpad in the core.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and width constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WCNT_W = 4;
  localparam int LANE_W = 8;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port DEPTH x 32 RAM, byte-write enables, synchronous read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read data only updates on a load, so it holds the last loaded word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) mem[idx][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with programmable wait states and stall output
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int                AW    = $clog2(DEPTH);
  localparam logic [31:0]       SPAN  = 32'(DEPTH) << 2;
  localparam logic [WCNT_W-1:0] WLOAD = WCNT_W'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] cnt, cnt_nxt;
  logic              commit;
  logic              accept;

  logic              cap_we;
  logic [31:0]       cap_addr, cap_wdata;
  logic [3:0]        cap_be;

  logic              c_we;
  logic [31:0]       c_addr, c_wdata, off;
  logic [3:0]        c_be;
  logic              c_err;
  logic              load_hit;
  logic [31:0]       ram_rdata;

  assign req_ready = (state != WAIT);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state == RESP);
  assign stall     = req_valid & ~req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (accept) begin
          cnt_nxt = WLOAD;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == WCNT_W'(1)) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit shares the accept edge, so use the live request.
  assign c_we    = (state == WAIT) ? cap_we    : req_we;
  assign c_addr  = (state == WAIT) ? cap_addr  : req_addr;
  assign c_wdata = (state == WAIT) ? cap_wdata : req_wdata;
  assign c_be    = (state == WAIT) ? cap_be    : req_be;

  // Offset compare avoids overflow of BASE_ADDR + SPAN at the top of the map.
  assign off   = c_addr - BASE_ADDR;
  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) || (off >= SPAN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rsp_err   <= 1'b0;
      load_hit  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end
      if (commit) begin
        rsp_err  <= c_err;
        load_hit <= ~c_we & ~c_err;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (commit & ~c_err & reset),
    .we    (c_we),
    .idx   (off[AW+1:2]),
    .wdata (c_wdata),
    .be    (c_be),
    .rdata (ram_rdata)
  );

  assign rsp_rdata = load_hit ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed, table-driven bench for dmem_responder at several wait-state settings
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n     [4];
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_we    [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic [3:0]  req_be    [4];
  logic        rsp_valid [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];
  logic        stall     [4];

  always #5 clk = ~clk;

  // Instance wait states: 0 -> 2, 1 -> 0, 2 -> 5, 3 -> 1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH       (256),
      .BASE_ADDR   (32'h0),
      .WAIT_CYCLES (g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 5 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .stall     (stall[g])
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t tv [20];
  vec_t bq [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input int i, input int k);
    req_valid[i] = 1'b1;
    req_we[i]    = bq[k].we;
    req_addr[i]  = bq[k].addr;
    req_wdata[i] = bq[k].wdata;
    req_be[i]    = bq[k].be;
  endtask

  // Issues bq[0..n-1] with req_valid held, checking data, error and latency of each response.
  task automatic burst(input int i, input int n, input int w, input string nm, output int stl);
    int ai, ri, cyc;
    int acc_cyc [8];
    bit acc;
    ai = 0; ri = 0; cyc = 0; stl = 0;
    @(negedge clk);
    drive(i, 0);
    while (ri < n && cyc < 200) begin
      #1;
      if (rsp_valid[i]) begin
        chk({nm, "_rdata"}, rsp_rdata[i], bq[ri].rdata);
        chk({nm, "_err"}, 32'(rsp_err[i]), 32'(bq[ri].err));
        chk({nm, "_latency"}, cyc - acc_cyc[ri], w + 1);
        ri++;
      end
      if (stall[i]) stl++;
      acc = req_valid[i] && req_ready[i];
      if (acc) acc_cyc[ai] = cyc;
      @(posedge clk);
      #1;
      if (acc) begin
        ai++;
        if (ai < n) drive(i, ai);
        else req_valid[i] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (ri < n) chk({nm, "_timeout"}, ri, n);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int stl;
    int pulses;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end

    tv[0]  = '{1'b1, 32'h000, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
    tv[1]  = '{1'b1, 32'h004, 32'h5566_7788, 4'hF, 32'h0,         1'b0};
    tv[2]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tv[3]  = '{1'b0, 32'h010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tv[4]  = '{1'b1, 32'h020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    tv[5]  = '{1'b1, 32'h020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    tv[6]  = '{1'b0, 32'h020, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
    tv[7]  = '{1'b0, 32'h022, 32'h0,         4'hF, 32'h0,         1'b1};
    tv[8]  = '{1'b0, 32'h400, 32'h0,         4'hF, 32'h0,         1'b1};
    tv[9]  = '{1'b1, 32'h404, 32'hBAD0_BAD0, 4'hF, 32'h0,         1'b1};
    tv[10] = '{1'b1, 32'h006, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    tv[11] = '{1'b0, 32'h000, 32'h0,         4'hF, 32'h0102_0304, 1'b0};
    tv[12] = '{1'b0, 32'h004, 32'h0,         4'hF, 32'h5566_7788, 1'b0};
    tv[13] = '{1'b1, 32'h3FC, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    tv[14] = '{1'b0, 32'h3FC, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
    tv[15] = '{1'b1, 32'h020, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    tv[16] = '{1'b0, 32'h020, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
    tv[17] = '{1'b1, 32'h010, 32'h0000_00EE, 4'h1, 32'h0,         1'b0};
    tv[18] = '{1'b0, 32'h010, 32'h0,         4'hF, 32'hDEAD_BEEE, 1'b0};
    tv[19] = '{1'b0, 32'h3FC, 32'hFFFF_FFFF, 4'h0, 32'h1234_5678, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready", 32'(req_ready[i]), 32'h1);
      chk("reset_rsp_valid", 32'(rsp_valid[i]), 32'h0);
      chk("reset_rdata", rsp_rdata[i], 32'h0);
      chk("reset_err", 32'(rsp_err[i]), 32'h0);
    end
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;

    for (int k = 0; k < 20; k++) begin
      bq[0] = tv[k];
      burst(0, 1, 2, $sformatf("vec%0d", k), stl);
    end

    // Back-to-back with valid held: each request waits out the previous one's 2 wait states.
    bq[0] = '{1'b1, 32'h050, 32'h1357_9BDF, 4'hF, 32'h0,         1'b0};
    bq[1] = '{1'b0, 32'h050, 32'h0,         4'hF, 32'h1357_9BDF, 1'b0};
    bq[2] = '{1'b0, 32'h010, 32'h0,         4'hF, 32'hDEAD_BEEE, 1'b0};
    burst(0, 3, 2, "b2b_w2", stl);
    chk("b2b_w2_stall_cycles", stl, 4);

    for (int k = 0; k < 4; k++) begin
      bq[k]   = '{1'b1, 32'(k * 4), 32'hA0A0_0000 + 32'(k), 4'hF, 32'h0, 1'b0};
      bq[k+4] = '{1'b0, 32'(k * 4), 32'h0, 4'hF, 32'hA0A0_0000 + 32'(k), 1'b0};
    end
    burst(1, 8, 0, "zero_wait", stl);
    chk("zero_wait_stall_cycles", stl, 0);

    bq[0] = '{1'b1, 32'h040, 32'h5A5A_5A5A, 4'hF, 32'h0,         1'b0};
    bq[1] = '{1'b0, 32'h040, 32'h0,         4'hF, 32'h5A5A_5A5A, 1'b0};
    burst(3, 2, 1, "raw_w1", stl);
    chk("raw_w1_stall_cycles", stl, 1);

    bq[0] = '{1'b1, 32'h030, 32'h0,         4'hF, 32'h0,         1'b0};
    bq[1] = '{1'b1, 32'h034, 32'h7777_7777, 4'hF, 32'h0,         1'b0};
    bq[2] = '{1'b0, 32'h034, 32'h0,         4'hF, 32'h7777_7777, 1'b0};
    burst(2, 3, 5, "pre_w5", stl);
    chk("pre_w5_stall_cycles", stl, 10);

    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h030;
    req_wdata[2] = 32'hCAFE_F00D; req_be[2] = 4'hF;
    #1;
    chk("rst_pre_ready", 32'(req_ready[2]), 32'h1);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("rst_rdata_held", rsp_rdata[2], 32'h7777_7777);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("rst_async_ready", 32'(req_ready[2]), 32'h1);
    chk("rst_async_rsp_valid", 32'(rsp_valid[2]), 32'h0);
    chk("rst_async_rdata", rsp_rdata[2], 32'h0);
    chk("rst_async_err", 32'(rsp_err[2]), 32'h0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[2]) pulses++;
    end
    chk("rst_no_response", pulses, 0);
    rst_n[2] = 1'b1;
    bq[0] = '{1'b0, 32'h030, 32'h0, 4'hF, 32'h0, 1'b0};
    burst(2, 1, 5, "post_rst_load", stl);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
